cpu: RTL and testbench



---
 rtl/cpu_pkg.sv | 22 ++
 rtl/cpu_alu.sv | 40 ++++
 rtl/cpu.sv | 101 ++++++++++
 tb/tb_cpu.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for the lvm-16 compute core.
//   WORD_W     datapath width
//   word_t     one datapath word
//   IS_C..J_GT bit positions of the fields in an instruction word
package cpu_pkg;

  localparam int unsigned WORD_W = 16;

  typedef logic [WORD_W-1:0] word_t;

  localparam int unsigned IS_C     = 15;
  localparam int unsigned A_SEL    = 12;
  localparam int unsigned COMP_MSB = 11;
  localparam int unsigned COMP_LSB = 6;
  localparam int unsigned DEST_A   = 5;
  localparam int unsigned DEST_D   = 4;
  localparam int unsigned DEST_M   = 3;
  localparam int unsigned J_LT     = 2;
  localparam int unsigned J_EQ     = 1;
  localparam int unsigned J_GT     = 0;

endpackage

// File: rtl/cpu_alu.sv
// cpu_alu: combinational ALU of the lvm-16 core.
//   x_i, y_i        operands
//   zx_i, nx_i      zero / invert x
//   zy_i, ny_i      zero / invert y
//   f_i             1 = add (mod 2^16), 0 = bitwise and
//   no_i            invert the result
//   out_o           result
//   zr_o, ng_o      result is zero / result is negative
module cpu_alu
  import cpu_pkg::*;
(
  input  logic [15:0] x_i,
  input  logic [15:0] y_i,
  input  logic        zx_i,
  input  logic        nx_i,
  input  logic        zy_i,
  input  logic        ny_i,
  input  logic        f_i,
  input  logic        no_i,
  output logic [15:0] out_o,
  output logic        zr_o,
  output logic        ng_o
);

  word_t x_m, y_m, res;

  always_comb begin
    x_m = zx_i ? '0 : x_i;
    if (nx_i) x_m = ~x_m;
    y_m = zy_i ? '0 : y_i;
    if (ny_i) y_m = ~y_m;
    res = f_i ? (x_m + y_m) : (x_m & y_m);
    if (no_i) res = ~res;
  end

  assign out_o = res;
  assign zr_o  = (res == '0);
  assign ng_o  = res[WORD_W-1];

endmodule

// File: rtl/cpu.sv
// cpu: lvm-16 accumulator-style core, one instruction per clock.
//   clk          system clock, rising edge
//   reset        asynchronous active-low reset
//   instruction  current instruction word (from instruction ROM at pc)
//   data         data-memory read value at addr (M)
//   out          ALU result, also data-memory write data
//   pc           current PC / instruction address
//   addr         data-memory address (A register)
//   write        data-memory write enable for this cycle
// Optional (macro CPU_DEBUG_EN): dbg_a, dbg_d register taps and dbg_jump.
module cpu
  import cpu_pkg::*;
#(
  parameter logic [15:0] PC_RESET = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] out,
  output logic [15:0] pc,
  output logic [15:0] addr,
  output logic        write,
  input  logic [15:0] instruction,
  input  logic [15:0] data
`ifdef CPU_DEBUG_EN
  ,
  output logic [15:0] dbg_a,
  output logic [15:0] dbg_d,
  output logic        dbg_jump
`endif
);

  word_t a_q, a_d;
  word_t d_q, d_d;
  word_t pc_q, pc_d;

  logic  is_c;
  word_t alu_y;
  word_t alu_out;
  logic  alu_zr, alu_ng;
  logic  take;

  assign is_c  = instruction[IS_C];
  assign alu_y = instruction[A_SEL] ? data : a_q;

  cpu_alu u_alu (
    .x_i   (d_q),
    .y_i   (alu_y),
    .zx_i  (instruction[COMP_MSB]),
    .nx_i  (instruction[COMP_MSB-1]),
    .zy_i  (instruction[COMP_MSB-2]),
    .ny_i  (instruction[COMP_MSB-3]),
    .f_i   (instruction[COMP_MSB-4]),
    .no_i  (instruction[COMP_LSB]),
    .out_o (alu_out),
    .zr_o  (alu_zr),
    .ng_o  (alu_ng)
  );

  assign take = is_c & ((instruction[J_LT] & alu_ng) |
                        (instruction[J_EQ] & alu_zr) |
                        (instruction[J_GT] & ~alu_ng & ~alu_zr));

  // All next-state values use pre-edge registers, so a jump with dA set
  // still targets the old A.
  always_comb begin
    a_d  = a_q;
    d_d  = d_q;
    pc_d = take ? a_q : (pc_q + 16'd1);
    if (!is_c) begin
      a_d = {1'b0, instruction[IS_C-1:0]};
    end else begin
      if (instruction[DEST_A]) a_d = alu_out;
      if (instruction[DEST_D]) d_d = alu_out;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_q  <= '0;
      d_q  <= '0;
      pc_q <= PC_RESET;
    end else begin
      a_q  <= a_d;
      d_q  <= d_d;
      pc_q <= pc_d;
    end
  end

  // Gating with reset drops any pending store the moment reset asserts.
  assign write = reset & is_c & instruction[DEST_M];
  assign out   = alu_out;
  assign pc    = pc_q;
  assign addr  = a_q;

`ifdef CPU_DEBUG_EN
  assign dbg_a    = a_q;
  assign dbg_d    = d_q;
  assign dbg_jump = take;
`endif

endmodule

// File: tb/tb_cpu.sv
module tb_cpu;

  logic        clk;
  logic        reset;
  logic [15:0] out;
  logic [15:0] pc;
  logic [15:0] addr;
  logic        write;
  logic [15:0] instruction;
  logic [15:0] data;
`ifdef CPU_DEBUG_EN
  logic [15:0] dbg_a;
  logic [15:0] dbg_d;
  logic        dbg_jump;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  cpu #(.PC_RESET(16'h0000)) dut (
    .clk         (clk),
    .reset       (reset),
    .out         (out),
    .pc          (pc),
    .addr        (addr),
    .write       (write),
    .instruction (instruction),
    .data        (data)
`ifdef CPU_DEBUG_EN
    ,
    .dbg_a       (dbg_a),
    .dbg_d       (dbg_d),
    .dbg_jump    (dbg_jump)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  logic [15:0] m_a, m_d, m_pc;

  // ALU from the instruction's arithmetic meaning, using integer arithmetic.
  function automatic logic [15:0] model_alu(input logic [15:0] ins, input logic [15:0] a,
                                            input logic [15:0] d, input logic [15:0] m);
    int x, y, r;
    logic [31:0] rv;
    x = ins[11] ? 0 : int'(d);
    if (ins[10]) x = 65535 - x;
    y = ins[9] ? 0 : int'(ins[12] ? m : a);
    if (ins[8]) y = 65535 - y;
    r = ins[7] ? ((x + y) % 65536) : (x & y);
    if (ins[6]) r = 65535 - r;
    rv = r;
    return rv[15:0];
  endfunction

  function automatic logic model_take(input logic [15:0] ins, input logic [15:0] res);
    int s;
    if (!ins[15]) return 1'b0;
    s = (int'(res) >= 32768) ? int'(res) - 65536 : int'(res);
    return (ins[2] && s < 0) || (ins[1] && s == 0) || (ins[0] && s > 0);
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_a  <= 16'h0000;
      m_d  <= 16'h0000;
      m_pc <= 16'h0000;
    end else begin
      logic [15:0] r;
      r = model_alu(instruction, m_a, m_d, data);
      if (!instruction[15]) m_a <= instruction & 16'h7FFF;
      else if (instruction[5]) m_a <= r;
      if (instruction[15] && instruction[4]) m_d <= r;
      if (model_take(instruction, r)) m_pc <= m_a;
      else m_pc <= 16'((32'(m_pc) + 1) % 65536);
    end
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    logic [15:0] e_out;
    e_out = model_alu(instruction, m_a, m_d, data);
    check("cyc_pc", pc, m_pc);
    check("cyc_addr", addr, m_a);
    check("cyc_write", {15'd0, write}, {15'd0, reset & instruction[15] & instruction[3]});
    check("cyc_out", out, e_out);
`ifdef CPU_DEBUG_EN
    check("cyc_dbg_a", dbg_a, m_a);
    check("cyc_dbg_d", dbg_d, m_d);
    check("cyc_dbg_jump", {15'd0, dbg_jump}, {15'd0, model_take(instruction, e_out)});
`endif
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input logic [15:0] ins, input logic [15:0] dat);
    instruction = ins;
    data        = dat;
    next_cycle();
  endtask

  initial begin
    reset       = 1'b0;
    instruction = 16'h0000;
    data        = 16'h0000;
    repeat (3) next_cycle();
    check("rst_pc", pc, 16'h0000);
    check("rst_addr", addr, 16'h0000);
    check("rst_write", {15'd0, write}, 16'd0);
    instruction = 16'hFDD8;  // store-type instruction while in reset
    #1;
    check("rst_write_dm", {15'd0, write}, 16'd0);
    instruction = 16'h0000;
    reset       = 1'b1;
    next_cycle();
    check("rel_pc", pc, 16'h0001);
    check("rel_addr", addr, 16'h0000);

    step(16'h6FFF, 16'h0000);
    check("aload_addr", addr, 16'h6FFF);
    check("aload_pc", pc, 16'h0002);
    check("aload_write", {15'd0, write}, 16'd0);

    instruction = 16'hEC10;  // D=A
    #1;
    check("dA_out", out, 16'h6FFF);
    check("dA_write", {15'd0, write}, 16'd0);
    next_cycle();
    check("dA_pc", pc, 16'h0003);

    instruction = 16'hFDD8;  // DM=M+1
    data        = 16'd50;
    #1;
    check("inc_out", out, 16'd51);
    check("inc_write", {15'd0, write}, 16'd1);
    next_cycle();
    check("inc_pc", pc, 16'h0004);

    step(16'h0005, 16'h0000);
    step(16'hEC10, 16'h0000);  // D=5
    step(16'h4000, 16'h0000);
    instruction = 16'hF60B;    // M=!D&0;JGE
    data        = 16'd5;
    #1;
    check("jz_out", out, 16'h0000);
    check("jz_write", {15'd0, write}, 16'd1);
    check("jz_addr", addr, 16'h4000);
    next_cycle();
    check("jz_pc", pc, 16'h4000);

    // Mixed arithmetic, jumps not taken and taken.
    step(16'h0009, 16'h0000);
    step(16'hE090, 16'h0000);  // D=D+A -> 14
    step(16'h0003, 16'h0000);
    step(16'hE4D4, 16'h0000);  // D=D-A;JLT -> 11, no jump
    step(16'h0020, 16'h0000);
    step(16'hE1D4, 16'h0000);  // D=A-D;JLT -> 21, no jump
    step(16'h0064, 16'h0000);
    step(16'hE4D4, 16'h0000);  // D=D-A -> negative, jump to 0x64
    check("jlt_pc", pc, 16'h0064);
    step(16'hF54D, 16'h0F00);  // M=D|M;JNE -> jump to 0x64
    check("jne_pc", pc, 16'h0064);
    step(16'hE7F7, 16'h0000);  // AD=D+1;JMP -> old A
    check("jmp_old_a_pc", pc, 16'h0064);

    // PC wrap.
    step(16'hEEA0, 16'h0000);  // A=-1
    check("neg1_addr", addr, 16'hFFFF);
    step(16'hEA87, 16'h0000);  // 0;JMP
    check("wrap_pre_pc", pc, 16'hFFFF);
    step(16'h0000, 16'h0000);
    check("wrap_pc", pc, 16'h0000);

    // Asynchronous reset between edges.
    step(16'h0123, 16'h0000);
    step(16'hEC10, 16'h0000);  // D=0x123
    instruction = 16'hFDD8;
    data        = 16'd7;
    #1;
    check("pre_rst_write", {15'd0, write}, 16'd1);
    reset = 1'b0;
    #1;
    check("arst_pc", pc, 16'h0000);
    check("arst_addr", addr, 16'h0000);
    check("arst_write", {15'd0, write}, 16'd0);
    check("arst_out_d0", out, 16'd8);  // M+1 with D cleared
    repeat (2) next_cycle();
    reset = 1'b1;
    step(16'h0000, 16'h0000);
    check("post_rst_pc", pc, 16'h0001);
    next_cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
